// File: rtl/snake_renderer.sv
// snake_renderer: walks a table of snake segments held in an external
// synchronous RAM and turns each entry into plot strobes for a VGA plotter.
// Each entry is {type[16:15], x[14:7], y[6:0]}; the type selects the colour.
// Optional feature: define SNAKE_BLOCK2X2_EN to draw every segment as a 2x2
// block of pixels instead of a single pixel.
module snake_renderer #(
  parameter logic [2:0] HEAD_COLOUR = 3'b010,
  parameter logic [2:0] BODY_COLOUR = 3'b111,
  parameter logic [2:0] FOOD_COLOUR = 3'b100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] length,
  input  logic [16:0] q,
  output logic [10:0] rd_address,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    LATCH,
    PLOT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [10:0] len_q, len_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  col_q, col_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  qType;
  logic [7:0]  qX;
  logic [6:0]  qY;
  logic        qOnScreen;
  logic        lastSeg;

  assign qType     = q[16:15];
  assign qX        = q[14:7];
  assign qY        = q[6:0];
  assign qOnScreen = (qX < 8'd160) && (qY < 7'd120);
  assign lastSeg   = (idx_q == (len_q - 11'd1));

`ifdef SNAKE_BLOCK2X2_EN
  // Base segment kept aside so the four sub-pixels can be derived from it
  logic [7:0]  segX_q, segX_d;
  logic [6:0]  segY_q, segY_d;
  logic [2:0]  segCol_q, segCol_d;
  logic        segOn_q, segOn_d;
  logic [1:0]  sub_q, sub_d;
  logic [1:0]  nextSub;
  logic [8:0]  pixX;
  logic [7:0]  pixY;
  logic        pixOn;

  assign nextSub = sub_q + 2'd1;
  assign pixX    = {1'b0, segX_q} + {8'd0, nextSub[0]};
  assign pixY    = {1'b0, segY_q} + {7'd0, nextSub[1]};
  assign pixOn   = segOn_q && (pixX < 9'd160) && (pixY < 8'd120);
`endif

  // Map the entry type onto its plot colour; type 3 erases
  function automatic logic [2:0] typeColour(input logic [1:0] t);
    case (t)
      2'b00:   typeColour = BODY_COLOUR;
      2'b01:   typeColour = HEAD_COLOUR;
      2'b10:   typeColour = FOOD_COLOUR;
      default: typeColour = 3'b000;
    endcase
  endfunction

  // Register all state and outputs; reset overrides any frame in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SNAKE_BLOCK2X2_EN
      segX_q   <= '0;
      segY_q   <= '0;
      segCol_q <= '0;
      segOn_q  <= 1'b0;
      sub_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SNAKE_BLOCK2X2_EN
      segX_q   <= segX_d;
      segY_q   <= segY_d;
      segCol_q <= segCol_d;
      segOn_q  <= segOn_d;
      sub_q    <= sub_d;
`endif
    end
  end

  // Next-state and next-output logic; strobes default low, data holds
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SNAKE_BLOCK2X2_EN
    segX_d   = segX_q;
    segY_d   = segY_q;
    segCol_d = segCol_q;
    segOn_d  = segOn_q;
    sub_d    = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = length;
          idx_d  = '0;
          busy_d = 1'b1;
          if (length == 11'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ADDR;
            addr_d  = '0;
          end
        end
      end
      ADDR: state_d = WAIT;
      WAIT: state_d = LATCH;
      LATCH: begin
        state_d = PLOT;
        if (qOnScreen) begin
          x_d    = qX;
          y_d    = qY;
          col_d  = typeColour(qType);
          plot_d = 1'b1;
        end
`ifdef SNAKE_BLOCK2X2_EN
        segX_d   = qX;
        segY_d   = qY;
        segCol_d = typeColour(qType);
        segOn_d  = qOnScreen;
        sub_d    = '0;
`endif
      end
      PLOT: begin
`ifdef SNAKE_BLOCK2X2_EN
        if (sub_q != 2'd3) begin
          sub_d = nextSub;
          if (pixOn) begin
            x_d    = pixX[7:0];
            y_d    = pixY[6:0];
            col_d  = segCol_q;
            plot_d = 1'b1;
          end
        end else if (lastSeg) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ADDR;
          idx_d   = idx_q + 11'd1;
          addr_d  = idx_q + 11'd1;
        end
`else
        if (lastSeg) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ADDR;
          idx_d   = idx_q + 11'd1;
          addr_d  = idx_q + 11'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_address = addr_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = col_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_snake_renderer.sv
// Self-checking bench for snake_renderer: a synchronous RAM model feeds the
// table, and every cycle of every frame is compared with a timing model
// computed from segment index and phase arithmetic.
module tb_snake_renderer;

`ifdef SNAKE_BLOCK2X2_EN
  localparam int PER  = 7;
  localparam int NPIX = 4;
`else
  localparam int PER  = 4;
  localparam int NPIX = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [10:0] length;
  logic [16:0] ramQ;
  logic [10:0] rdAddress;
  logic [7:0]  pixX;
  logic [6:0]  pixY;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  logic [16:0] ram [0:2047];
  logic [7:0]  expX;
  logic [6:0]  expY;
  logic [2:0]  expCol;
  int          errors;
  int          checks;

  snake_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .length     (length),
    .q          (ramQ),
    .rd_address (rdAddress),
    .x          (pixX),
    .y          (pixY),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: one cycle of latency from address to data
  always @(posedge clk) ramQ <= ram[rdAddress];

  function automatic logic [16:0] mkEntry(input int t, input int ex, input int ey);
    logic [1:0] tt;
    logic [7:0] xx;
    logic [6:0] yy;
    tt = t[1:0];
    xx = ex[7:0];
    yy = ey[6:0];
    mkEntry = {tt, xx, yy};
  endfunction

  function automatic logic [2:0] refColour(input logic [1:0] t);
    case (t)
      2'b01:   refColour = 3'b010;
      2'b00:   refColour = 3'b111;
      2'b10:   refColour = 3'b100;
      default: refColour = 3'b000;
    endcase
  endfunction

  // Which pixel (if any) should be plotted t cycles after the accepting edge
  function automatic bit modelPixel(input int t, input int len,
                                    output logic [7:0] ex, output logic [6:0] ey,
                                    output logic [2:0] ec);
    int u, seg, ph, bx, by, px, py;
    logic [16:0] e;
    ex = '0;
    ey = '0;
    ec = '0;
    if (t < 3) return 1'b0;
    u   = t - 3;
    seg = u / PER;
    ph  = u % PER;
    if (seg >= len || ph >= NPIX) return 1'b0;
    e  = ram[seg];
    bx = int'(e[14:7]);
    by = int'(e[6:0]);
    px = bx + (ph % 2);
    py = by + (ph / 2);
    if (bx < 160 && by < 120 && px < 160 && py < 120) begin
      ex = px[7:0];
      ey = py[6:0];
      ec = refColour(e[16:15]);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Run one frame and compare every output on every cycle until idle again
  task automatic run_frame(input int len, input int restartAt, input string tag);
    logic [7:0] mx;
    logic [6:0] my;
    logic [2:0] mc;
    bit         ePlot;
    logic [10:0] eAddr;
    @(negedge clk);
    start  = 1'b1;
    length = len[10:0];
    @(posedge clk);
    for (int t = 0; t <= PER * len + 2; t++) begin
      @(negedge clk);
      if (t == 0) begin
        start  = 1'b0;
        length = 11'($urandom);
      end
      if (t == restartAt) begin
        start  = 1'b1;
        length = 11'd1;
      end
      if (t == restartAt + 1) start = 1'b0;
      ePlot = modelPixel(t, len, mx, my, mc);
      if (ePlot) begin
        expX   = mx;
        expY   = my;
        expCol = mc;
      end
      checks++;
      if (plot !== ePlot) begin
        errors++;
        $display("[TB] FAIL %s plot t=%0d got=%0b exp=%0b", tag, t, plot, ePlot);
      end
      checks++;
      if (done !== (t == PER * len)) begin
        errors++;
        $display("[TB] FAIL %s done t=%0d got=%0b exp=%0b", tag, t, done, (t == PER * len));
      end
      checks++;
      if (busy !== (t <= PER * len)) begin
        errors++;
        $display("[TB] FAIL %s busy t=%0d got=%0b exp=%0b", tag, t, busy, (t <= PER * len));
      end
      checks++;
      if ({pixX, pixY, colour} !== {expX, expY, expCol}) begin
        errors++;
        $display("[TB] FAIL %s pixel t=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                 tag, t, pixX, pixY, colour, expX, expY, expCol);
      end
      if (t < PER * len) begin
        eAddr = 11'(t / PER);
        checks++;
        if (rdAddress !== eAddr) begin
          errors++;
          $display("[TB] FAIL %s rd_address t=%0d got=%0d exp=%0d", tag, t, rdAddress, eAddr);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    length  = 11'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdAddress, pixX, pixY, colour, plot, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got=%0h exp=0", {rdAddress, pixX, pixY, colour, plot, busy, done});
    end
    start   = 1'b0;
    reset_n = 1'b1;
    expX    = '0;
    expY    = '0;
    expCol  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_idle got=%0b exp=000", {plot, busy, done});
    end
  endtask

  task automatic test_basic();
    ram[0] = mkEntry(1, 20, 10);
    for (int i = 1; i < 6; i++) ram[i] = mkEntry(0, 20, 10 + i);
    run_frame(6, -10, "basic");
  endtask

  task automatic test_zero_length();
    run_frame(0, -10, "zero_len");
  endtask

  task automatic test_offscreen();
    ram[0] = mkEntry(0, 30, 40);
    ram[1] = mkEntry(0, 200, 50);
    ram[2] = mkEntry(2, 50, 60);
    run_frame(3, -10, "offscreen");
  endtask

  task automatic test_boundary();
    ram[0] = mkEntry(2, 159, 5);
    ram[1] = mkEntry(0, 159, 119);
    ram[2] = mkEntry(1, 160, 0);
    ram[3] = mkEntry(0, 0, 120);
    ram[4] = mkEntry(3, 0, 0);
    ram[5] = mkEntry(0, 255, 127);
    ram[6] = mkEntry(1, 158, 118);
    run_frame(7, -10, "boundary");
  endtask

  task automatic test_restart();
    for (int i = 0; i < 5; i++) ram[i] = mkEntry(i % 4, 10 * i, 5 * i);
    run_frame(5, 6, "restart");
  endtask

  task automatic test_reset_midframe();
    int tHit;
    tHit = 3 + PER * 2;
    for (int i = 0; i < 4; i++) ram[i] = mkEntry(0, 40 + i, 30);
    @(negedge clk);
    start  = 1'b1;
    length = 11'd4;
    @(posedge clk);
    for (int t = 0; t <= tHit; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (plot !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_preplot got=%0b exp=1", plot);
    end
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdAddress, pixX, pixY, colour, plot, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_state got=%0h exp=0", {rdAddress, pixX, pixY, colour, plot, busy, done});
    end
    reset_n = 1'b1;
    start   = 1'b0;
    expX    = '0;
    expY    = '0;
    expCol  = '0;
    for (int t = 0; t < 2 * PER; t++) begin
      @(negedge clk);
      checks++;
      if ({plot, busy, done} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL midreset_idle t=%0d got=%0b exp=000", t, {plot, busy, done});
      end
    end
    run_frame(4, -10, "post_reset");
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 8; f++) begin
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++)
        ram[i] = mkEntry(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 127)));
      run_frame(len, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : -10, "random");
    end
  endtask

  task automatic test_max_length();
    for (int i = 0; i < 2048; i++)
      ram[i] = mkEntry(int'($urandom_range(0, 3)), int'($urandom_range(0, 170)),
                       int'($urandom_range(0, 127)));
    run_frame(2047, -10, "max_len");
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    length  = '0;
    expX    = '0;
    expY    = '0;
    expCol  = '0;
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    $display("[TB] snake_renderer bench, period %0d cycles per segment", PER);
    test_reset();
    test_basic();
    test_zero_length();
    test_offscreen();
    test_boundary();
    test_restart();
    test_reset_midframe();
    test_random();
    test_max_length();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
